synth_voice_bank: RTL

- Parametrised successor to the two-wave `Synthesizer`: a time-multiplexed bank of VOICES oscillators feeding one mixer.
- Each voice has its own phase-increment, volume, waveform (square/saw/triangle/noise) and gate.
- Once per sample period the bank walks all voices one per clock, mixes them with saturation, and emits one signed PCM sample.
- Sits on the audio clock between the game/CPU register writes and AUDIO_L/AUDIO_R.

---
 rtl/synth_voice_bank.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/synth_voice_bank.sv
// synth_voice_bank: a time-multiplexed bank of VOICES oscillators (square,
// saw, triangle, noise) walked one voice per clock once per sample period,
// mixed into a saturating accumulator and emitted as one signed PCM sample.
module synth_voice_bank #(
  parameter int VOICES     = 8,
  parameter int PHASE_W    = 18,
  parameter int SAMPLE_DIV = 20,
  parameter int MIX_SHIFT  = 2,
  parameter int OUT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       wr_en,
  input  logic [$clog2(VOICES)-1:0]  wr_voice,
  input  logic [1:0]                 wr_sel,
  input  logic [15:0]                wr_data,
  output logic signed [OUT_W-1:0]    sample_out,
  output logic                       sample_valid,
  output logic                       busy
);

  localparam int VW    = $clog2(VOICES);
  localparam int ACC_W = 16 + VW + 1;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t state, state_next;

  // Per-voice register file written by the CPU side.
  logic [15:0]        inc   [VOICES];
  logic [7:0]         vol   [VOICES];
  logic [1:0]         wave  [VOICES];
  logic               gate  [VOICES];
  logic [PHASE_W-1:0] phase [VOICES];

  logic [DIV_W-1:0]         div;
  logic                     tick;
  logic [VW-1:0]            v;
  logic signed [ACC_W-1:0]  acc;
  logic [15:0]              lfsr;

  // Current-voice datapath signals.
  logic [PHASE_W-1:0]       p;
  logic [7:0]               tri_val;
  logic signed [7:0]        s;
  logic signed [ACC_W-1:0]  s_ext;
  logic signed [ACC_W-1:0]  vol_ext;
  logic signed [ACC_W-1:0]  contrib;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  shifted;
  logic [OUT_W-1:0]         sat_val;
  logic                     last_voice;
  logic                     lfsr_fb;

  assign last_voice = (v == VW'(VOICES - 1));
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Sample-rate divider; tick is a registered pulse in the cycle the count wraps to 0.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= enable && (div == DIV_W'(SAMPLE_DIV - 1));
      if (enable) div <= (div == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next-state logic.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (tick) state_next = ACCUM;
      ACCUM:   if (last_voice) state_next = OUTPUT;
      OUTPUT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Waveform generation, voice contribution, running mix and saturation.
  always_comb begin
    p       = phase[v];
    tri_val = p[PHASE_W-1] ? ~p[PHASE_W-2 -: 8] : p[PHASE_W-2 -: 8];
    s       = '0;
    unique case (wave[v])
      2'd0: s = p[PHASE_W-1] ? -8'sd127 : 8'sd127;
      2'd1: s = p[PHASE_W-1 -: 8] - 8'd128;
      2'd2: s = tri_val - 8'd128;
      2'd3: s = lfsr[7:0];
      default: s = '0;
    endcase
    s_ext    = ACC_W'(s);
    vol_ext  = ACC_W'({1'b0, vol[v]});
    contrib  = gate[v] ? s_ext * vol_ext : '0;
    acc_next = acc + contrib;
    shifted  = acc_next >>> MIX_SHIFT;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
    else                        sat_val = shifted[OUT_W-1:0];
  end

  // Frame datapath: accumulate one voice per cycle, publish the sample, step the LFSR.
  // NOTE: the phase array is reset because every oscillator must restart from phase 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc          <= '0;
      v            <= '0;
      busy         <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      lfsr         <= 16'hACE1;
      for (int i = 0; i < VOICES; i++) phase[i] <= '0;
    end else begin
      sample_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tick) begin
            acc  <= '0;
            v    <= '0;
            busy <= 1'b1;
          end
        end
        ACCUM: begin
          acc      <= acc_next;
          v        <= v + 1'b1;
          phase[v] <= gate[v] ? p + PHASE_W'(inc[v]) : '0;
          if (last_voice) begin
            sample_out   <= sat_val;
            sample_valid <= 1'b1;
          end
        end
        OUTPUT: begin
          busy <= 1'b0;
          lfsr <= {lfsr[14:0], lfsr_fb};
        end
        default: ;
      endcase
    end
  end

  // CPU register writes; they land at the edge, so the voice in its slot this cycle sees old values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < VOICES; i++) begin
        inc[i]  <= '0;
        vol[i]  <= '0;
        wave[i] <= '0;
        gate[i] <= 1'b0;
      end
    end else if (wr_en) begin
      unique case (wr_sel)
        2'd0: inc[wr_voice] <= wr_data;
        2'd1: vol[wr_voice] <= wr_data[7:0];
        2'd2: begin
          gate[wr_voice] <= wr_data[2];
          wave[wr_voice] <= wr_data[1:0];
        end
        default: ;
      endcase
    end
  end

  // A new tick must never land while a frame is still in progress.
  tick_while_busy : assert property (@(posedge clk) disable iff (!reset_n)
                                      !(tick && state != IDLE));

endmodule
